// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
// Purpose: FSM state enum, grant enum, default address width and the
//          byte-lane enable decode used by the arbiter datapath.
// Ports:   none (package).
package mem_arb_pkg;

  localparam int MEM_ADDR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

  // One-hot byte lane enable for a byte address offset inside a 32-bit word.
  function automatic logic [3:0] byte_lane_en(input logic [1:0] lane);
    byte_lane_en = 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and shared-memory signal bundle
// Purpose: groups the instruction-fetch port, the data byte port and the
//          shared 32-bit memory port into one interface.
// Modports: slave  - the arbiter (takes requests, drives memory strobes)
//           master - the environment (requesters and memory)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEFAULT
);
  logic                  I_READ;
  logic [MEM_ADDR_W-1:0] I_ADDR;
  logic [31:0]           I_DATA;
  logic                  I_BUSYWAIT;

  logic                  D_READ;
  logic                  D_WRITE;
  logic [MEM_ADDR_W-1:0] D_ADDR;
  logic [7:0]            D_WRITEDATA;
  logic [7:0]            D_READDATA;
  logic                  D_BUSYWAIT;

  logic                  M_READ;
  logic                  M_WRITE;
  logic [MEM_ADDR_W-1:0] M_ADDR;
  logic [3:0]            M_BYTEEN;
  logic [31:0]           M_WRITEDATA;
  logic [31:0]           M_READDATA;
  logic                  M_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    input  M_READDATA, M_BUSYWAIT,
    output I_DATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
    output M_READ, M_WRITE, M_ADDR, M_BYTEEN, M_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    output M_READDATA, M_BUSYWAIT,
    input  I_DATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
    input  M_READ, M_WRITE, M_ADDR, M_BYTEEN, M_WRITEDATA
  );

endinterface

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin pick, purely combinational
// Purpose: chooses between the fetch and data requesters; a lone requester
//          wins, on contention the side not granted last time wins.
// Ports:   req_instr, req_data - pending requests
//          last_gnt            - side granted most recently
//          gnt                 - chosen side (meaningful when any request is high)
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_instr,
  input  logic req_data,
  input  gnt_e last_gnt,
  output gnt_e gnt
);

  always_comb begin
    gnt = GNT_INSTR;
    if (req_instr && req_data) begin
      gnt = (last_gnt == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    end else if (req_data) begin
      gnt = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data ports onto one shared memory
// Purpose: IDLE -> ACCESS -> RESP sequencer. A grant latches the winner's
//          address/data into registers that drive the memory strobes for the
//          whole access; completion captures the read word and opens a
//          one-cycle response window in which the winner's BUSYWAIT drops.
// Ports:   CLK   - single clock, rising edge
//          RESET - synchronous, active high
//          bus   - fetch port (I_*), data byte port (D_*), memory port (M_*)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEFAULT
) (
  input logic                CLK,
  input logic                RESET,
  mem_port_arbiter_if.slave  bus
);

  state_e                state;
  state_e                state_next;
  gnt_e                  gnt;
  gnt_e                  gnt_pick;
  logic                  i_req;
  logic                  d_req;
  logic                  grant_en;
  logic                  done;

  logic                  m_read;
  logic                  m_write;
  logic [MEM_ADDR_W-1:0] m_addr;
  logic [3:0]            m_byteen;
  logic [31:0]           m_writedata;
  logic [1:0]            lane;
  logic [31:0]           i_data;
  logic [7:0]            d_readdata;

  // Fetches are word aligned; the low address bits carry no information.
  logic                  unused_i_addr_lsbs;
  assign unused_i_addr_lsbs = ^bus.I_ADDR[1:0];

  assign i_req = bus.I_READ;
  assign d_req = bus.D_READ | bus.D_WRITE;

  // gnt doubles as the last-granted side for round-robin purposes.
  arb_rr2 u_arb (
    .req_instr (i_req),
    .req_data  (d_req),
    .last_gnt  (gnt),
    .gnt       (gnt_pick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_next = ST_ACCESS;
          grant_en   = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!bus.M_BUSYWAIT) begin
          state_next = ST_RESP;
          done       = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt         <= GNT_INSTR;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_addr      <= '0;
      m_byteen    <= '0;
      m_writedata <= '0;
      lane        <= '0;
      i_data      <= '0;
      d_readdata  <= '0;
    end else if (grant_en) begin
      gnt <= gnt_pick;
      if (gnt_pick == GNT_INSTR) begin
        m_read      <= 1'b1;
        m_write     <= 1'b0;
        m_addr      <= {bus.I_ADDR[MEM_ADDR_W-1:2], 2'b00};
        m_byteen    <= 4'b1111;
        m_writedata <= '0;
      end else begin
        m_read      <= bus.D_READ;
        m_write     <= bus.D_WRITE;
        m_addr      <= {bus.D_ADDR[MEM_ADDR_W-1:2], 2'b00};
        m_byteen    <= byte_lane_en(bus.D_ADDR[1:0]);
        m_writedata <= {4{bus.D_WRITEDATA}};
        lane        <= bus.D_ADDR[1:0];
      end
    end else if (done) begin
      // Address, lanes and write data stay put; only the strobes drop.
      m_read  <= 1'b0;
      m_write <= 1'b0;
      if (gnt == GNT_INSTR) begin
        i_data <= bus.M_READDATA;
      end else if (m_read) begin
        // A store returns nothing meaningful, so the load byte is left alone.
        d_readdata <= bus.M_READDATA[{lane, 3'b000} +: 8];
      end
    end
  end

  assign bus.M_READ      = m_read;
  assign bus.M_WRITE     = m_write;
  assign bus.M_ADDR      = m_addr;
  assign bus.M_BYTEEN    = m_byteen;
  assign bus.M_WRITEDATA = m_writedata;
  assign bus.I_DATA      = i_data;
  assign bus.D_READDATA  = d_readdata;

  assign bus.I_BUSYWAIT = i_req & ~((state == ST_RESP) & (gnt == GNT_INSTR));
  assign bus.D_BUSYWAIT = d_req & ~((state == ST_RESP) & (gnt == GNT_DATA));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.MEM_ADDR_W(10)) bus ();

  mem_port_arbiter #(.MEM_ADDR_W(10)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [256];
  int  cfg_waits  = 0;
  bit  rand_waits = 0;
  int  wl         = 0;
  bit  prev_act   = 0;

  // Transaction-level reference: side 0 = fetch, 1 = data.
  bit          model_ok = 0;
  bit          m_inflight, m_resp, m_resp_side, m_side, m_last, m_wr;
  logic [1:0]  m_lane;
  logic [7:0]  m_byte;
  logic [9:0]  e_addr;
  logic [3:0]  e_ben;
  logic [31:0] e_wd, e_idata;
  logic [7:0]  e_drd;
  bit          e_rd, e_wr;
  int          wait_i = 0, wait_d = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ir, dr;
    ir = bus.I_READ;
    dr = bus.D_READ | bus.D_WRITE;
    if (rst) begin
      model_ok = 1; m_inflight = 0; m_resp = 0; m_last = 0;
      e_addr = '0; e_ben = '0; e_wd = '0; e_idata = '0; e_drd = '0; e_rd = 0; e_wr = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_inflight) begin
      if (!bus.M_BUSYWAIT) begin
        m_inflight = 0; m_resp = 1; m_resp_side = m_side; e_rd = 0; e_wr = 0;
        if (m_side == 0) e_idata = mem[e_addr[9:2]];
        else if (m_wr) mem[e_addr[9:2]][{m_lane, 3'b000} +: 8] = m_byte;
        else e_drd = mem[e_addr[9:2]][{m_lane, 3'b000} +: 8];
      end
    end else if (ir || dr) begin
      if (ir && dr) m_side = ~m_last;
      else m_side = dr;
      m_last = m_side;
      m_inflight = 1;
      if (m_side == 0) begin
        e_addr = {bus.I_ADDR[9:2], 2'b00}; e_ben = 4'hF; e_wd = '0; e_rd = 1; e_wr = 0;
      end else begin
        m_lane = bus.D_ADDR[1:0];
        e_addr = {bus.D_ADDR[9:2], 2'b00};
        e_ben  = 4'b0001 << m_lane;
        e_wd   = {4{bus.D_WRITEDATA}};
        e_rd   = bus.D_READ; e_wr = bus.D_WRITE;
        m_wr   = bus.D_WRITE; m_byte = bus.D_WRITEDATA;
      end
    end
  endtask

  task automatic mem_drive();
    bit act;
    act = bus.M_READ | bus.M_WRITE;
    if (act && !prev_act) wl = rand_waits ? int'($urandom_range(0, 3)) : cfg_waits;
    if (act) begin
      bus.M_BUSYWAIT = (wl > 0);
      if (wl > 0) wl--;
    end else begin
      bus.M_BUSYWAIT = 1'($urandom_range(0, 1));
    end
    bus.M_READDATA = (act && !bus.M_BUSYWAIT) ? mem[bus.M_ADDR[9:2]] : $urandom;
    prev_act = act;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    mem_drive();
  endtask

  task automatic compare_model();
    bit dreq, ib_exp, db_exp;
    dreq   = bus.D_READ | bus.D_WRITE;
    ib_exp = bus.I_READ && !(m_resp && m_resp_side == 0);
    db_exp = dreq && !(m_resp && m_resp_side == 1);
    chk("i_busywait",  32'(bus.I_BUSYWAIT),  32'(ib_exp));
    chk("d_busywait",  32'(bus.D_BUSYWAIT),  32'(db_exp));
    chk("m_read",      32'(bus.M_READ),      32'(e_rd));
    chk("m_write",     32'(bus.M_WRITE),     32'(e_wr));
    chk("m_addr",      32'(bus.M_ADDR),      32'(e_addr));
    chk("m_byteen",    32'(bus.M_BYTEEN),    32'(e_ben));
    chk("m_writedata", bus.M_WRITEDATA,      e_wd);
    chk("i_data",      bus.I_DATA,           e_idata);
    chk("d_readdata",  32'(bus.D_READDATA),  32'(e_drd));
    // No side may sit through more than one foreign response while waiting.
    if (!bus.I_READ) wait_i = 0;
    else if (!bus.I_BUSYWAIT) begin chk("fair_instr", 32'(wait_i <= 1), 32'd1); wait_i = 0; end
    else if (dreq && !bus.D_BUSYWAIT) wait_i++;
    if (!dreq) wait_d = 0;
    else if (!bus.D_BUSYWAIT) begin chk("fair_data", 32'(wait_d <= 1), 32'd1); wait_d = 0; end
    else if (bus.I_READ && !bus.I_BUSYWAIT) wait_d++;
  endtask

  task automatic sample();
    @(negedge clk);
    if (model_ok) compare_model();
  endtask

  task automatic idle(input int n);
    repeat (n) begin step(); sample(); end
  endtask

  bit i_act = 0, i_done = 0, d_done = 0;

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    bus.I_READ = 0; bus.I_ADDR = '0; bus.D_READ = 0; bus.D_WRITE = 0;
    bus.D_ADDR = '0; bus.D_WRITEDATA = '0; bus.M_BUSYWAIT = 0; bus.M_READDATA = '0;

    // Reset
    idle(2);
    step(); rst = 0; sample();
    chk("rst_i_data", bus.I_DATA, 32'h0);
    chk("rst_d_readdata", 32'(bus.D_READDATA), 32'h0);
    chk("rst_m_read", 32'(bus.M_READ), 32'h0);
    chk("rst_m_write", 32'(bus.M_WRITE), 32'h0);
    chk("rst_m_addr", 32'(bus.M_ADDR), 32'h0);
    chk("rst_m_byteen", 32'(bus.M_BYTEEN), 32'h0);
    chk("rst_m_writedata", bus.M_WRITEDATA, 32'h0);

    // Fetch 0x004, zero-wait memory
    mem[1] = 32'h01020304; cfg_waits = 0;
    step(); bus.I_READ = 1; bus.I_ADDR = 10'h004; sample();
    step(); sample();
    chk("fetch_m_addr", 32'(bus.M_ADDR), 32'h004);
    step(); sample();
    chk("fetch_busywait_c3", 32'(bus.I_BUSYWAIT), 32'h0);
    chk("fetch_i_data", bus.I_DATA, 32'h01020304);
    step(); bus.I_READ = 0; mem[1] = 32'hAABBCCDD; sample();

    // Data byte read at 0x06 with five memory waits
    step(); bus.D_READ = 1; bus.D_ADDR = 10'h006; cfg_waits = 5; sample();
    step(); sample();
    chk("dread_byteen", 32'(bus.M_BYTEEN), 32'b0100);
    chk("dread_m_addr", 32'(bus.M_ADDR), 32'h004);
    idle(5);
    chk("dread_busy_c7", 32'(bus.D_BUSYWAIT), 32'h1);
    step(); sample();
    chk("dread_byte_c8", 32'(bus.D_READDATA), 32'hBB);
    chk("dread_busywait_c8", 32'(bus.D_BUSYWAIT), 32'h0);
    step(); bus.D_READ = 0; sample();

    // Data byte write at 0x03
    step(); bus.D_WRITE = 1; bus.D_ADDR = 10'h003; bus.D_WRITEDATA = 8'h5A; cfg_waits = 0; sample();
    step(); sample();
    chk("dwrite_m_write", 32'(bus.M_WRITE), 32'h1);
    chk("dwrite_m_addr", 32'(bus.M_ADDR), 32'h000);
    chk("dwrite_byteen", 32'(bus.M_BYTEEN), 32'b1000);
    chk("dwrite_wdata", bus.M_WRITEDATA, 32'h5A5A5A5A);
    step(); sample();
    step(); bus.D_WRITE = 0; sample();

    // Unaligned fetch address
    step(); bus.I_READ = 1; bus.I_ADDR = 10'h00B; sample();
    step(); sample();
    chk("unaligned_m_addr", 32'(bus.M_ADDR), 32'h008);
    step(); sample();
    step(); bus.I_READ = 0; sample();

    // Simultaneous fetch and data read, both held
    step(); bus.I_READ = 1; bus.I_ADDR = 10'h020; bus.D_READ = 1; bus.D_ADDR = 10'h011; sample();
    step(); sample();
    chk("rr_first_data", 32'(bus.M_BYTEEN), 32'b0010);
    step(); sample();
    chk("rr_data_resp", 32'(bus.D_BUSYWAIT), 32'h0);
    chk("rr_instr_waits", 32'(bus.I_BUSYWAIT), 32'h1);
    idle(1);
    step(); sample();
    chk("rr_then_instr", 32'(bus.M_BYTEEN), 32'hF);
    idle(2);
    step(); sample();
    chk("rr_data_again", 32'(bus.M_BYTEEN), 32'b0010);
    step(); sample();
    step(); bus.I_READ = 0; bus.D_READ = 0; sample();

    // Reset pulse during a stalled access
    step(); bus.I_READ = 1; bus.I_ADDR = 10'h010; cfg_waits = 10; sample();
    step(); sample();
    step(); rst = 1; sample();
    step(); rst = 0; cfg_waits = 0; sample();
    chk("rst_abort_m_read", 32'(bus.M_READ), 32'h0);
    chk("rst_abort_busywait", 32'(bus.I_BUSYWAIT), 32'h1);
    step(); sample();
    chk("rst_regrant", 32'(bus.M_READ), 32'h1);
    step(); sample();
    chk("rst_regrant_done", 32'(bus.I_BUSYWAIT), 32'h0);
    step(); bus.I_READ = 0; sample();

    // Random traffic; the opening stretch keeps both sides reading continuously
    rand_waits = 1;
    for (int c = 0; c < 900; c++) begin
      bit force_on;
      force_on = (c < 120);
      step();
      if (i_done || (i_act && !force_on && $urandom_range(0, 40) == 0)) i_act = 0;
      if (!i_act && (force_on || $urandom_range(0, 2) == 0)) begin
        i_act = 1; bus.I_ADDR = 10'($urandom);
      end
      bus.I_READ = i_act;
      if (d_done || ((bus.D_READ || bus.D_WRITE) && !force_on && $urandom_range(0, 40) == 0)) begin
        bus.D_READ = 0; bus.D_WRITE = 0;
      end
      if (!(bus.D_READ || bus.D_WRITE) && (force_on || $urandom_range(0, 2) == 0)) begin
        if (!force_on && $urandom_range(0, 1) == 1) bus.D_WRITE = 1;
        else bus.D_READ = 1;
        bus.D_ADDR = 10'($urandom);
        bus.D_WRITEDATA = 8'($urandom);
      end
      sample();
      i_done = bus.I_READ && !bus.I_BUSYWAIT;
      d_done = (bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MEM_ADDR_W, default 10, byte-address width of shared memory (1024 bytes).
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: I_READ  input  1  instruction-fetch request, held until I_BUSYWAIT low.
REQ-005 Port: I_ADDR  input  MEM_ADDR_W  fetch byte address, word aligned ([1:0]=0).
REQ-006 Port: I_DATA  output  32  fetched word; byte at I_ADDR in [7:0], little-endian.
REQ-007 Port: I_BUSYWAIT  output  1  stall to fetch side.
REQ-008 Port: D_READ, D_WRITE  input  1 each  data-side byte read/write request; never both high.
REQ-009 Port: D_ADDR  input  MEM_ADDR_W  data byte address.
REQ-010 Port: D_WRITEDATA  input  8  store byte; D_READDATA  output  8  load byte.
REQ-011 Port: D_BUSYWAIT  output  1  stall to data side.
REQ-012 Port: M_READ, M_WRITE  output  1 each  shared-memory request strobes.
REQ-013 Port: M_ADDR  output  MEM_ADDR_W  word-aligned address; M_BYTEEN  output  4  byte lanes.
REQ-014 Port: M_WRITEDATA  output  32; M_READDATA  input  32; M_BUSYWAIT  input  1 (memory stall).

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; one grant register GNT in {INSTR, DATA}.
REQ-016 IDLE: on an edge with any request pending, latch winner, its address/data, enter ACCESS.
REQ-017 Arbitration: single requester wins; both pending -> winner is the side not granted last (round-robin); LAST_GNT resets to INSTR (first contention goes to DATA).
REQ-018 ACCESS: M_READ/M_WRITE/M_ADDR/M_BYTEEN/M_WRITEDATA driven from latched registers, stable all cycles of ACCESS.
REQ-019 Instruction grant: M_READ=1, M_ADDR=I_ADDR, M_BYTEEN=4'b1111.
REQ-020 Data grant: M_ADDR={D_ADDR[MSB:2],2'b00}; M_BYTEEN one-hot at D_ADDR[1:0]; write replicates D_WRITEDATA to all four lanes of M_WRITEDATA.
REQ-021 Completion: first edge in ACCESS (including first ACCESS edge) with M_BUSYWAIT=0; capture M_READDATA, drop strobes, enter RESP.
REQ-022 RESP lasts exactly one cycle, then IDLE; new grant no earlier than the edge after RESP.
REQ-023 X_BUSYWAIT = X request high AND NOT (state==RESP AND GNT==X); combinational.
REQ-024 I_DATA holds last captured instruction word; D_READDATA holds byte lane D_ADDR[1:0] of last captured data word; both change only on data-capturing edges.
REQ-025 Minimum latency request->BUSYWAIT low: 3 cycles with zero-wait memory; +1 per M_BUSYWAIT-high edge.
REQ-026 Requester dropping request during ACCESS: access still completes at memory; result captured, no other effect.
REQ-027 Request with unaligned I_ADDR: low two bits ignored.

Reset
REQ-028 RESET high at an edge: state=IDLE, LAST_GNT=INSTR, M_READ=M_WRITE=0, M_BYTEEN=0, M_ADDR=0, M_WRITEDATA=0, I_DATA=0, D_READDATA=0.
REQ-029 Reset mid-ACCESS aborts; strobes low after that edge; no RESP produced.
REQ-030 During reset both BUSYWAITs follow REQ-023 (high if requested).

Structure
REQ-031 Package mem_arb_pkg SHALL hold state enum, grant enum, MEM_ADDR_W default, byte-lane decode function.
REQ-032 Round-robin pick SHALL be sub-module arb_rr2 (2 requests, last-grant input, grant output, combinational).

Verification
REQ-033 Fetch I_ADDR=0x004, memory 0 waits, word 0x01020304 -> I_BUSYWAIT low 3rd cycle, I_DATA=0x01020304.
REQ-034 D_READ D_ADDR=0x06, memory returns 0xAABBCCDD after 5 waits -> M_BYTEEN=4'b0100, D_READDATA=0xBB at cycle 8.
REQ-035 D_WRITE D_ADDR=0x03 data 0x5A -> M_WRITE=1, M_ADDR=0x000, M_BYTEEN=4'b1000, M_WRITEDATA=0x5A5A5A5A.
REQ-036 I_READ and D_READ raised same edge, held -> DATA served first, then INSTR; next simultaneous pair served DATA again only after INSTR grant.
REQ-037 RESET pulsed 1 cycle during ACCESS with M_BUSYWAIT high -> strobes low next cycle, state IDLE, held request re-granted afterward.
REQ-038 Continuous I_READ and D_READ for 20 requests -> grants alternate, no side waits more than one foreign access.
